// File: rtl/present_pkg.sv
// Shared PRESENT-80 constants, FSM state type and pure round/key-schedule functions.
package present_pkg;

    localparam int unsigned KEY_W     = 80;
    localparam int unsigned BLK_W     = 64;
    localparam int unsigned NR_ROUNDS = 32;

    // Nibble i of each table holds the S-box output for input i.
    localparam logic [63:0] SBOX     = 64'h2174_8FE3_DA09_B65C;
    localparam logic [63:0] SBOX_INV = 64'hA970_364B_D21C_8FE5;

    typedef enum logic [1:0] {
        StIdle,
        StKeyExp,
        StDecrypt,
        StDone
    } state_e;

    function automatic logic [3:0] sbox4(input logic [3:0] x);
        return SBOX[{x, 2'b00} +: 4];
    endfunction

    function automatic logic [3:0] sbox4_inv(input logic [3:0] x);
        return SBOX_INV[{x, 2'b00} +: 4];
    endfunction

    function automatic logic [BLK_W-1:0] sbox_layer(input logic [BLK_W-1:0] w);
        logic [BLK_W-1:0] o;
        for (int n = 0; n < 16; n++) begin
            o[4*n +: 4] = sbox4(w[4*n +: 4]);
        end
        return o;
    endfunction

    function automatic logic [BLK_W-1:0] inv_sbox_layer(input logic [BLK_W-1:0] w);
        logic [BLK_W-1:0] o;
        for (int n = 0; n < 16; n++) begin
            o[4*n +: 4] = sbox4_inv(w[4*n +: 4]);
        end
        return o;
    endfunction

    function automatic logic [BLK_W-1:0] p_layer(input logic [BLK_W-1:0] w);
        logic [BLK_W-1:0] o;
        for (int j = 0; j < 64; j++) begin
            o[16*(j%4) + j/4] = w[j];
        end
        return o;
    endfunction

    function automatic logic [BLK_W-1:0] inv_p_layer(input logic [BLK_W-1:0] w);
        logic [BLK_W-1:0] o;
        for (int j = 0; j < 64; j++) begin
            o[j] = w[16*(j%4) + j/4];
        end
        return o;
    endfunction

    // Rotate left by 61, S-box the top nibble, fold the round counter into [19:15].
    function automatic logic [KEY_W-1:0] key_fwd(input logic [KEY_W-1:0] k,
                                                 input logic [4:0]       i);
        return {sbox4(k[18:15]), k[14:0], k[79:39], k[38:34] ^ i, k[33:19]};
    endfunction

    function automatic logic [KEY_W-1:0] key_inv(input logic [KEY_W-1:0] k,
                                                 input logic [4:0]       i);
        logic [KEY_W-1:0] r;
        r          = k;
        r[19:15]   = r[19:15] ^ i;
        r[79:76]   = sbox4_inv(r[79:76]);
        return {r[60:0], r[79:61]};
    endfunction

endpackage

// File: rtl/present_inv_round.sv
// One PRESENT-80 inverse round: step the key back, then undo p-layer and S-box layer.
module present_inv_round
    import present_pkg::*;
(
    input  logic [63:0] word_i,
    input  logic [79:0] rk_i,
    input  logic [4:0]  round_i,
    output logic [63:0] word_o,
    output logic [79:0] rk_o
);

    logic [KEY_W-1:0] nk;

    always_comb begin
        nk     = key_inv(rk_i, round_i);
        rk_o   = nk;
        word_o = inv_sbox_layer(inv_p_layer(word_i)) ^ nk[79:16];
    end

endmodule

// File: rtl/present_decoder.sv
// PRESENT-80 decryptor: expands and caches the final round key, then runs 31 inverse rounds.
module present_decoder #(
    parameter logic [79:0] INITIAL_KEY = 80'h0,
    parameter int unsigned NR_ROUNDS   = 32
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [1:0]  pl_i,
    input  logic [79:0] in_text_i,
    output logic [63:0] plaintext_o,
    output logic        done_o
);

    import present_pkg::*;

    localparam logic [5:0] LastRound = 6'(NR_ROUNDS - 1);

    state_e      state_q, state_d;
    logic [79:0] mk_q, mk_d;
    logic [79:0] klast_q, klast_d;
    logic        key_valid_q, key_valid_d;
    logic [63:0] ct_q, ct_d;
    logic        pending_q, pending_d;
    logic [63:0] word_q, word_d;
    logic [79:0] rk_q, rk_d;
    logic [5:0]  cnt_q, cnt_d;

    logic [79:0] fwd_rk;
    logic [63:0] inv_word;
    logic [79:0] inv_rk;

    present_inv_round u_inv_round (
        .word_i  (word_q),
        .rk_i    (rk_q),
        .round_i (cnt_q[4:0]),
        .word_o  (inv_word),
        .rk_o    (inv_rk)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            mk_q        <= INITIAL_KEY;
            klast_q     <= '0;
            key_valid_q <= 1'b0;
            ct_q        <= '0;
            pending_q   <= 1'b0;
            word_q      <= '0;
            rk_q        <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            mk_q        <= mk_d;
            klast_q     <= klast_d;
            key_valid_q <= key_valid_d;
            ct_q        <= ct_d;
            pending_q   <= pending_d;
            word_q      <= word_d;
            rk_q        <= rk_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mk_d        = mk_q;
        klast_d     = klast_q;
        key_valid_d = key_valid_q;
        ct_d        = ct_q;
        pending_d   = pending_q;
        word_d      = word_q;
        rk_d        = rk_q;
        cnt_d       = cnt_q;
        fwd_rk      = key_fwd(rk_q, cnt_q[4:0]);

        unique case (state_q)
            StIdle, StDone: begin
                if (pl_i[1]) begin
                    mk_d        = in_text_i;
                    rk_d        = in_text_i;
                    key_valid_d = 1'b0;
                    cnt_d       = 6'd1;
                    state_d     = StKeyExp;
                    if (pl_i[0]) begin
                        ct_d      = in_text_i[63:0];
                        pending_d = 1'b1;
                    end
                end else if (pl_i[0]) begin
                    if (key_valid_q) begin
                        word_d  = in_text_i[63:0] ^ klast_q[79:16];
                        rk_d    = klast_q;
                        cnt_d   = LastRound;
                        state_d = StDecrypt;
                    end else begin
                        ct_d      = in_text_i[63:0];
                        pending_d = 1'b1;
                        rk_d      = mk_q;
                        cnt_d     = 6'd1;
                        state_d   = StKeyExp;
                    end
                end
            end
            StKeyExp: begin
                rk_d  = fwd_rk;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == LastRound) begin
                    klast_d     = fwd_rk;
                    key_valid_d = 1'b1;
                    if (pending_q) begin
                        word_d    = ct_q ^ fwd_rk[79:16];
                        cnt_d     = LastRound;
                        pending_d = 1'b0;
                        state_d   = StDecrypt;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StDecrypt: begin
                word_d = inv_word;
                rk_d   = inv_rk;
                cnt_d  = cnt_q - 6'd1;
                if (cnt_q == 6'd1) begin
                    state_d = StDone;
                end
            end
        endcase
    end

    always_comb begin
        done_o      = (state_q == StDone);
        plaintext_o = done_o ? word_q : 64'h0;
    end

endmodule

// File: tb/tb_present_decoder.sv
// Self-checking bench for present_decoder using a scoreboard of expected plaintexts and latencies.
module tb_present_decoder;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [1:0]  pl_i;
    logic [79:0] in_text_i;
    logic [63:0] plaintext_o;
    logic        done_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        logic [63:0] pt;
        int          lat;
        bit          chk_pt;
    } exp_t;

    exp_t sb_q[$];

    logic [3:0] tb_sbox [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                 4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

    present_decoder #(
        .INITIAL_KEY (80'h0),
        .NR_ROUNDS   (32)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .pl_i        (pl_i),
        .in_text_i   (in_text_i),
        .plaintext_o (plaintext_o),
        .done_o      (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference PRESENT-80 encryption, written in the textbook rotate/S-box/counter form.
    function automatic logic [63:0] enc(input logic [79:0] key, input logic [63:0] pt);
        logic [79:0] k;
        logic [63:0] s;
        logic [63:0] t;
        logic [4:0]  rc;
        k = key;
        s = pt;
        for (int r = 1; r <= 31; r++) begin
            s = s ^ k[79:16];
            for (int n = 0; n < 16; n++) t[4*n +: 4] = tb_sbox[s[4*n +: 4]];
            for (int b = 0; b < 63; b++) s[(b*16) % 63] = t[b];
            s[63] = t[63];
            rc = 5'(r);
            k = {k[18:0], k[79:19]};
            k[79:76] = tb_sbox[k[79:76]];
            k[19:15] = k[19:15] ^ rc;
        end
        return s ^ k[79:16];
    endfunction

    task automatic expect_result(input string tag, input logic [63:0] pt, input int lat,
                                 input bit chk_pt);
        exp_t e;
        e.tag    = tag;
        e.pt     = pt;
        e.lat    = lat;
        e.chk_pt = chk_pt;
        sb_q.push_back(e);
    endtask

    // Pulse pl for one edge; returns 1 time unit after the load edge.
    task automatic send(input logic [1:0] pl, input logic [79:0] txt);
        @(posedge clk_i);
        #1;
        pl_i      = pl;
        in_text_i = txt;
        @(posedge clk_i);
        #1;
        pl_i = 2'b00;
        chk("load_done_low", 64'(done_o), 64'd0);
    endtask

    // Count edges until done; inject ignored strobes at the given cycle offsets.
    task automatic wait_result(input int busy_a, input int busy_b);
        exp_t e;
        int   n;
        n = 0;
        while (!done_o && n < 200) begin
            if (n == busy_a || n == busy_b) begin
                pl_i      = 2'b11;
                in_text_i = {$urandom(), $urandom(), $urandom()};
            end
            @(posedge clk_i);
            #1;
            pl_i = 2'b00;
            n++;
        end
        if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            chk({e.tag, "_lat"}, 64'(n), 64'(e.lat));
            if (e.chk_pt) chk({e.tag, "_pt"}, plaintext_o, e.pt);
        end
    endtask

    task automatic do_reset();
        @(posedge clk_i);
        #1;
        reset_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        reset_i = 1'b0;
    endtask

    initial begin
        logic [95:0] rnd;
        logic [79:0] key;
        logic [63:0] pt;

        reset_i   = 1'b1;
        pl_i      = 2'b00;
        in_text_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("reset_done", 64'(done_o), 64'd0);
        chk("reset_pt", plaintext_o, 64'd0);
        reset_i = 1'b0;

        // Zero key and zero word loaded together: full expansion plus decrypt.
        expect_result("zero_kt", 64'h0, 62, 1'b0);
        send(2'b11, 80'h0);
        wait_result(-1, -1);
        expect_result("zero_ct", 64'h0, 31, 1'b1);
        send(2'b01, {16'h0, 64'h5579C1387B228445});
        wait_result(-1, -1);
        repeat (5) @(posedge clk_i);
        #1;
        chk("done_hold", 64'(done_o), 64'd1);
        chk("pt_hold", plaintext_o, 64'h0);

        // All-ones key, cached and reused for two words.
        send(2'b10, {80{1'b1}});
        repeat (31) @(posedge clk_i);
        #1;
        chk("keyonly_idle", 64'(done_o), 64'd0);
        expect_result("ones_a", 64'h0, 31, 1'b1);
        send(2'b01, {16'h0, 64'hE72C46C0F5945049});
        wait_result(-1, -1);
        expect_result("ones_b", 64'hFFFFFFFFFFFFFFFF, 31, 1'b1);
        send(2'b01, {16'h0, 64'h3333DCD3213210D2});
        wait_result(-1, -1);

        // No cached key: uses INITIAL_KEY and the long path.
        do_reset();
        expect_result("nokey", 64'hFFFFFFFFFFFFFFFF, 62, 1'b1);
        send(2'b01, {16'h0, 64'hA112FFC72F68417B});
        wait_result(-1, -1);

        // Strobes while busy must be ignored.
        expect_result("busy_dec", 64'h0, 31, 1'b1);
        send(2'b01, {16'h0, 64'h5579C1387B228445});
        wait_result(5, 20);
        do_reset();
        expect_result("busy_kexp", 64'hFFFFFFFFFFFFFFFF, 62, 1'b1);
        send(2'b01, {16'h0, 64'hA112FFC72F68417B});
        wait_result(10, 40);

        // Reset in the middle of decryption drops the cached key.
        send(2'b01, {16'h0, 64'h5579C1387B228445});
        repeat (9) @(posedge clk_i);
        #1;
        reset_i = 1'b1;
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        chk("midrst_done", 64'(done_o), 64'd0);
        chk("midrst_pt", plaintext_o, 64'd0);
        expect_result("after_rst", 64'h0, 62, 1'b1);
        send(2'b01, {16'h0, 64'h5579C1387B228445});
        wait_result(-1, -1);

        // Random key/text round trips, two texts per key.
        for (int k = 0; k < 100; k++) begin
            rnd = {$urandom(), $urandom(), $urandom()};
            key = rnd[79:0];
            send(2'b10, key);
            repeat (31) @(posedge clk_i);
            for (int t = 0; t < 2; t++) begin
                pt = {$urandom(), $urandom()};
                expect_result("rand", pt, 31, 1'b1);
                send(2'b01, {16'h0, enc(key, pt)});
                wait_result(-1, -1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
